serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised multi-bit adder/subtractor built around the one-bit full-adder cell, processed LSB-first over several clock cycles.
- Uses a start/busy/done handshake so a controller can launch an operation and wait for its result.
- Reports sum, carry-out and signed overflow.
- Intended as the sequential, width-generic successor to the single-bit combinational full adder in the lab datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is 1 or greater.
- BITS_PER_CYCLE, 1, bits resolved per clock by a ripple chain of full-adder cells; must divide WIDTH exactly.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract; latched at start.
- a  input  WIDTH  operand A; latched at start.
- b  input  WIDTH  operand B; latched at start.
- cin  input  1  carry-in for add mode; latched at start; ignored when sub=1.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; held stable from done until the next start is accepted.
- cout  output  1  final carry-out (in sub mode, 1 = no borrow).
- overflow  output  1  signed two's-complement overflow of the result.

Behaviour:
- Reset (rst_n low, asynchronous): FSM goes to IDLE.
  - busy=0, done=0, sum=0, cout=0, overflow=0.
  - Internal operand and carry registers are cleared.
  - Reset asserted mid-operation discards the operation; no done pulse is generated.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge latches a, b, cin and sub, loads the step counter with 0, and moves to RUN; busy=1 from that edge.
  - Operand B is latched as b when sub=0 and as ~b when sub=1.
  - Initial carry is cin when sub=0 and 1 when sub=1.
- RUN:
  - Each edge resolves the next BITS_PER_CYCLE bits, LSB first, through a full-adder chain.
  - Result bits are shifted into the sum shift register; the carry register is updated.
  - N = WIDTH/BITS_PER_CYCLE. After the Nth RUN edge, the FSM goes to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0.
  - sum, cout and overflow are valid in this cycle and remain held afterwards.
  - Next edge returns to IDLE.
- Latency: start is sampled at edge k; done is high during the cycle following edge k+N. With defaults, done follows start by 8 cycles.
- Overflow = carry into the MSB XOR carry out of the MSB, captured on the final RUN step. With WIDTH=1 this is cin XOR cout of that single bit.
- sum, cout and overflow are updated only at the DONE transition; internal partial results are not visible on the ports.
- start while busy or in DONE is ignored (no queueing). start held high continuously launches a new operation on the first IDLE edge after DONE, giving a throughput of one operation per N+2 cycles.
- Operand inputs may change freely after the start edge without affecting the operation in progress.
- Wrap-around: the sum is modulo 2^WIDTH; the carry is reported only via cout.

Optional Feature:
- Macro: SERIAL_ADDER_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge in RUN returns the FSM to IDLE with busy=0 and no done pulse.
  - sum, cout and overflow keep their previous values.
  - abort is ignored in IDLE and DONE.
  - If abort and start are both high in IDLE, start wins.
- When undefined: no abort port; every accepted operation runs to completion.

Test Plan (WIDTH=8, BITS_PER_CYCLE=1 unless stated):
- Exhaustive 1-bit table with WIDTH=1, all 8 combinations of a/b/cin in add mode -> sum/cout match the full-adder truth table, done one cycle after start.
- Add a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0, done exactly 8 cycles after the start edge.
- Add a=8'h7F, b=8'h01 -> sum=8'h80, overflow=1, cout=0. Subtract a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, overflow=0.
- Hold start high and change a/b every cycle -> operand changes after the start edge are ignored, operations are spaced 10 cycles apart, and start during busy does not restart.
- Assert rst_n low mid-RUN (cycle 4) -> all outputs 0 immediately, no done pulse; a new start after release works normally.
- WIDTH=16, BITS_PER_CYCLE=4, a=16'h1234, b=16'hEDCC -> sum=16'h0000, cout=1, done 4 cycles after start. With SERIAL_ADDER_ABORT_EN, abort at cycle 2 -> no done, previous sum held.

Source files
------------

// File: rtl/serial_adder.sv
// LSB-first multi-cycle adder/subtractor: BITS_PER_CYCLE full-adder cells per clock, start/busy/done handshake.
// Define SERIAL_ADDER_ABORT_EN to add an abort input that cancels an operation in RUN.
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    // Handshake: start is accepted only in IDLE; busy is high in RUN;
    // done pulses for the single DONE cycle, when sum/cout/overflow are valid.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state;
    state_t                    state_next;
    logic [WIDTH-1:0]          op_a;
    logic [WIDTH-1:0]          op_b;
    logic [WIDTH-1:0]          acc;
    logic [WIDTH-1:0]          acc_next;
    logic                      carry;
    logic [CNT_W-1:0]          step;
    logic [BITS_PER_CYCLE-1:0] slice_sum;
    logic [BITS_PER_CYCLE:0]   chain;
    logic                      last_step;
    logic                      abort_req;

`ifdef SERIAL_ADDER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign last_step = (step == CNT_W'(STEPS - 1));

    // Ripple chain over the low slice of the operand shift registers.
    always_comb begin
        chain     = '0;
        slice_sum = '0;
        chain[0]  = carry;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            slice_sum[i] = op_a[i] ^ op_b[i] ^ chain[i];
            chain[i+1]   = (op_a[i] & op_b[i]) | (chain[i] & (op_a[i] ^ op_b[i]));
        end
        acc_next = acc >> BITS_PER_CYCLE;
        acc_next[WIDTH-1 -: BITS_PER_CYCLE] = slice_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                if (abort_req) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            step     <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        step  <= '0;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    if (!abort_req) begin
                        op_a  <= op_a >> BITS_PER_CYCLE;
                        op_b  <= op_b >> BITS_PER_CYCLE;
                        carry <= chain[BITS_PER_CYCLE];
                        acc   <= acc_next;
                        step  <= step + CNT_W'(1);
                        // Ports change only here, so partial results never leak out.
                        if (last_step) begin
                            sum      <= acc_next;
                            cout     <= chain[BITS_PER_CYCLE];
                            overflow <= chain[BITS_PER_CYCLE] ^ chain[BITS_PER_CYCLE-1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder: three configurations (8/1, 1/1, 16/4)
// checked against an arithmetic reference model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // inst 0: WIDTH=8 BPC=1, inst 1: WIDTH=1 BPC=1, inst 2: WIDTH=16 BPC=4
    logic        start8 = 0, sub8 = 0, cin8 = 0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        start1 = 0, sub1 = 0, cin1 = 0;
    logic        a1 = 0, b1 = 0;
    logic        busy1, done1, cout1, ovf1;
    logic        sum1;
    logic        start16 = 0, sub16 = 0, cin16 = 0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;
`ifdef SERIAL_ADDER_ABORT_EN
    logic        abort8 = 0, abort1 = 0, abort16 = 0;
`endif

    logic [17:0] prev_exp [3];
    logic [17:0] exp_q [$];

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_add8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_ABORT_EN
        .abort(abort8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    serial_adder #(.WIDTH(1), .BITS_PER_CYCLE(1)) u_add1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_ABORT_EN
        .abort(abort1),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_add16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_ABORT_EN
        .abort(abort16),
`endif
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int width_of(input int inst);
        return (inst == 0) ? 8 : (inst == 1) ? 1 : 16;
    endfunction

    function automatic int steps_of(input int inst);
        return (inst == 0) ? 8 : (inst == 1) ? 1 : 4;
    endfunction

    // Result packed as {overflow, cout, sum zero-extended to 16 bits}.
    function automatic logic [17:0] ref_result(input int w, input logic [15:0] ta, input logic [15:0] tb,
                                               input logic tc, input logic ts);
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(ta) & m;
        longint ub   = (ts ? ~longint'(tb) : longint'(tb)) & m;
        longint c0   = ts ? 1 : longint'(tc);
        longint full = ua + ub + c0;
        longint sa   = (ua >= half) ? ua - (m + 1) : ua;
        longint sb   = (ub >= half) ? ub - (m + 1) : ub;
        longint r    = sa + sb + c0;
        logic   ov   = (r >= half) || (r < -half);
        logic   co   = full[w];
        logic [15:0] s = 16'(full & m);
        return {ov, co, s};
    endfunction

    function automatic logic [17:0] dut_res(input int inst);
        case (inst)
            0:       return {ovf8, cout8, 8'h00, sum8};
            1:       return {ovf1, cout1, 15'h0000, sum1};
            default: return {ovf16, cout16, sum16};
        endcase
    endfunction

    function automatic logic get_done(input int inst);
        return (inst == 0) ? done8 : (inst == 1) ? done1 : done16;
    endfunction

    function automatic logic get_busy(input int inst);
        return (inst == 0) ? busy8 : (inst == 1) ? busy1 : busy16;
    endfunction

    task automatic drive(input int inst, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic ts, input logic tst);
        case (inst)
            0: begin a8 = ta[7:0]; b8 = tb[7:0]; cin8 = tc; sub8 = ts; start8 = tst; end
            1: begin a1 = ta[0]; b1 = tb[0]; cin1 = tc; sub1 = ts; start1 = tst; end
            default: begin a16 = ta; b16 = tb; cin16 = tc; sub16 = ts; start16 = tst; end
        endcase
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic run_op(input int inst, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic ts, output logic [17:0] res);
        int lat = 0;
        logic [17:0] exp = ref_result(width_of(inst), ta, tb, tc, ts);
        drive(inst, ta, tb, tc, ts, 1'b1);
        @(posedge clk); #1;
        check("busy_after_start", 32'(get_busy(inst)), 32'd1);
        check("held_after_start", 32'(dut_res(inst)), 32'(prev_exp[inst]));
        drive(inst, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        while (!get_done(inst) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (!get_done(inst)) begin
                check("busy_in_run", 32'(get_busy(inst)), 32'd1);
            end
        end
        check("latency", 32'(lat), 32'(steps_of(inst)));
        check("busy_in_done", 32'(get_busy(inst)), 32'd0);
        res = dut_res(inst);
        check("result", 32'(res), 32'(exp));
        prev_exp[inst] = exp;
        @(posedge clk); #1;
        check("done_one_cycle", 32'(get_done(inst)), 32'd0);
        check("result_held", 32'(dut_res(inst)), 32'(exp));
    endtask

    initial begin
        logic [17:0] res;
        int last_done;
        int n_done;
        int seen;
        for (int i = 0; i < 3; i++) prev_exp[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_busy", 32'(get_busy(i)), 32'd0);
            check("reset_done", 32'(get_done(i)), 32'd0);
            check("reset_result", 32'(dut_res(i)), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases
        run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, res);
        check("ff_plus_01", 32'(res), {14'd0, 1'b0, 1'b1, 16'h0000});
        run_op(0, 16'h007F, 16'h0001, 1'b0, 1'b0, res);
        check("7f_plus_01", 32'(res), {14'd0, 1'b1, 1'b0, 16'h0080});
        run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, res);
        check("05_minus_07", 32'(res), {14'd0, 1'b0, 1'b0, 16'h00FE});
        run_op(2, 16'h1234, 16'hEDCC, 1'b0, 1'b0, res);
        check("w16_wrap", 32'(res), {14'd0, 1'b0, 1'b1, 16'h0000});

        // Full-adder truth table on the 1-bit instance
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v = 3'(i);
            run_op(1, {15'd0, v[0]}, {15'd0, v[1]}, v[2], 1'b0, res);
            check("fa_sum", 32'(res[0]), 32'(v[0] ^ v[1] ^ v[2]));
            check("fa_cout", 32'(res[16]), 32'((v[0] & v[1]) | (v[2] & (v[0] ^ v[1]))));
        end

        // Random operations on every configuration
        for (int i = 0; i < 25; i++)
            run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), res);
        for (int i = 0; i < 8; i++)
            run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), res);
        for (int i = 0; i < 12; i++)
            run_op(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), res);

        // start held high with operands changing every cycle: launches every N+2 cycles
        last_done = -1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra = 16'($urandom);
            logic [15:0] rb = 16'($urandom);
            logic rc = 1'($urandom);
            logic rs = 1'($urandom);
            drive(0, ra, rb, rc, rs, (i <= 30));
            if (i % 10 == 0 && i <= 30) exp_q.push_back(ref_result(8, ra, rb, rc, rs));
            @(posedge clk); #1;
            if (done8) begin
                n_done++;
                if (last_done >= 0) check("held_start_gap", 32'(i - last_done), 32'd10);
                last_done = i;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    prev_exp[0] = exp_q.pop_front();
                    check("held_start_result", 32'(dut_res(0)), 32'(prev_exp[0]));
                end
            end
        end
        check("held_start_count", 32'(n_done), 32'd4);
        check("held_start_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;

        // Reset during RUN discards the operation
        drive(0, 16'h00A5, 16'h003C, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", 32'(busy8), 32'd0);
        check("midrun_reset_done", 32'(done8), 32'd0);
        check("midrun_reset_result", 32'(dut_res(0)), 32'd0);
        check("midrun_reset_result16", 32'(dut_res(2)), 32'd0);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) seen++;
        end
        check("midrun_reset_no_done", 32'(seen), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) prev_exp[i] = '0;
        @(posedge clk); #1;
        run_op(0, 16'h0033, 16'h0044, 1'b1, 1'b0, res);
        check("after_reset_op", 32'(res), {14'd0, 1'b0, 1'b0, 16'h0078});

`ifdef SERIAL_ADDER_ABORT_EN
        run_op(2, 16'h1111, 16'h2222, 1'b0, 1'b0, res);
        drive(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        abort16 = 1'b1;
        @(posedge clk); #1;
        abort16 = 1'b0;
        check("abort_busy", 32'(busy16), 32'd0);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done16) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_result_held", 32'(dut_res(2)), 32'(prev_exp[2]));
        run_op(2, 16'h8000, 16'h8000, 1'b0, 1'b0, res);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
